// File: rtl/counter_seq_ctrl_if.sv
// Control/feedback bundle between the sequencer and the external up-counter.
// The master side is the sequencer; the slave side is the controller and counter.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 16
);
  logic             start;
  logic             abort;
  logic             mode_reload;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_v;
  logic             cnt_inc;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, mode_reload, start_val, end_val, prescale, count,
    output cnt_ld, cnt_v, cnt_inc, busy, done
  );

  modport slave (
    output start, abort, mode_reload, start_val, end_val, prescale, count,
    input  cnt_ld, cnt_v, cnt_inc, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Runs an external up-counter from start_val to end_val, one increment every
// prescale+1 cycles, with one-shot or auto-reload repetition.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  counter_seq_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [WIDTH-1:0] start_q, end_q;
  logic [PRE_W-1:0] pre_q;
  logic             reload_q;
  logic             accept;
  logic             ld, inc, fin;

  assign accept = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      start_q  <= '0;
      end_q    <= '0;
      pre_q    <= '0;
      reload_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= pre_nxt;
      if (accept) begin
        start_q  <= bus.start_val;
        end_q    <= bus.end_val;
        pre_q    <= bus.prescale;
        reload_q <= bus.mode_reload;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    ld        = 1'b0;
    inc       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        ld = !bus.abort;
        if (bus.abort) state_nxt = IDLE;
        else begin
          state_nxt = RUN;
          pre_nxt   = pre_q;
        end
      end
      RUN: begin
        // Terminal count wins over the prescale tick, so the last value is
        // held for exactly one cycle before DONE.
        if (bus.abort)                state_nxt = IDLE;
        else if (bus.count == end_q)  state_nxt = DONE;
        else if (pre_cnt == '0) begin
          inc     = 1'b1;
          pre_nxt = pre_q;
        end else                      pre_nxt = pre_cnt - 1'b1;
      end
      DONE: begin
        fin = !bus.abort;
        if (bus.abort)     state_nxt = IDLE;
        else if (reload_q) state_nxt = LOAD;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cnt_ld  = ld;
  assign bus.cnt_v   = start_q;
  assign bus.cnt_inc = inc;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = fin;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural up-counter on the
// feedback path.
module tb_counter_seq_ctrl;
  localparam int W = 8;
  localparam int P = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(W), .PRE_W(P)) bus ();

  counter_seq_ctrl #(.WIDTH(W), .PRE_W(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External up-counter driven only by the sequencer.
  logic [W-1:0] cnt_q = '0;
  always @(posedge clk) begin
    if (bus.cnt_ld)       cnt_q <= bus.cnt_v;
    else if (bus.cnt_inc) cnt_q <= cnt_q + 1'b1;
  end
  assign bus.count = cnt_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [W-1:0] sv, input logic [W-1:0] ev,
                    input logic [P-1:0] pre, input logic md);
    bus.start_val   = sv;
    bus.end_val     = ev;
    bus.prescale    = pre;
    bus.mode_reload = md;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Starts in the LOAD cycle; tallies outputs until busy drops.
  task automatic run_seq(output int incs, output int dones, output int lds, output int cyc);
    incs = 0; dones = 0; lds = 0; cyc = 0;
    while (bus.busy && cyc < 300) begin
      incs  += int'(bus.cnt_inc);
      dones += int'(bus.done);
      lds   += int'(bus.cnt_ld);
      cyc++;
      step();
    end
    chk("seq_timeout", 32'(bus.busy), 0);
  endtask

  int incs, dones, lds, cyc;

  initial begin
    bus.start = 0; bus.abort = 0; bus.mode_reload = 0;
    bus.start_val = 0; bus.end_val = 0; bus.prescale = 0;
    step(); step();
    chk("rst_ld",   32'(bus.cnt_ld), 0);
    chk("rst_inc",  32'(bus.cnt_inc), 0);
    chk("rst_v",    32'(bus.cnt_v), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b1;
    step();

    // Basic one-shot 3 -> 5
    go(3, 5, 0, 0);
    chk("b_ld1",  32'(bus.cnt_ld), 1);
    chk("b_v1",   32'(bus.cnt_v), 3);
    chk("b_busy1", 32'(bus.busy), 1);
    chk("b_inc1", 32'(bus.cnt_inc), 0);
    step();
    chk("b_cnt2", 32'(bus.count), 3);
    chk("b_inc2", 32'(bus.cnt_inc), 1);
    chk("b_ld2",  32'(bus.cnt_ld), 0);
    step();
    chk("b_cnt3", 32'(bus.count), 4);
    chk("b_inc3", 32'(bus.cnt_inc), 1);
    step();
    chk("b_cnt4", 32'(bus.count), 5);
    chk("b_inc4", 32'(bus.cnt_inc), 0);
    chk("b_done4", 32'(bus.done), 0);
    step();
    chk("b_done5", 32'(bus.done), 1);
    chk("b_busy5", 32'(bus.busy), 1);
    step();
    chk("b_done6", 32'(bus.done), 0);
    chk("b_busy6", 32'(bus.busy), 0);

    // Prescale 3, 0 -> 2; start_val change mid-run is ignored
    go(0, 2, 3, 0);
    chk("p_ld", 32'(bus.cnt_ld), 1);
    step();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) bus.start_val = 8'd77;
      chk($sformatf("p_inc%0d", i), 32'(bus.cnt_inc), (i == 3 || i == 7) ? 1 : 0);
      chk($sformatf("p_v%0d", i), 32'(bus.cnt_v), 0);
      step();
    end
    chk("p_done", 32'(bus.done), 1);
    step();
    chk("p_idle", 32'(bus.busy), 0);

    // Wrap 254 -> 1
    go(254, 1, 0, 0);
    run_seq(incs, dones, lds, cyc);
    chk("w_incs",  32'(incs), 3);
    chk("w_dones", 32'(dones), 1);
    chk("w_cyc",   32'(cyc), 6);
    chk("w_cnt",   32'(cnt_q), 1);

    // Equal start/end
    go(7, 7, 0, 0);
    run_seq(incs, dones, lds, cyc);
    chk("e_incs",  32'(incs), 0);
    chk("e_dones", 32'(dones), 1);
    chk("e_cyc",   32'(cyc), 3);

    // Auto-reload 0 -> 1, start pulses while busy ignored
    go(0, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("r_ld%0d", i),   32'(bus.cnt_ld), (i % 4 == 0) ? 1 : 0);
      chk($sformatf("r_done%0d", i), 32'(bus.done), (i % 4 == 3) ? 1 : 0);
      chk($sformatf("r_v%0d", i),    32'(bus.cnt_v), 0);
      bus.start     = (i == 5 || i == 8);
      bus.start_val = 8'd9;
      step();
    end
    bus.start = 0;
    bus.abort = 1;
    #1;
    chk("r_ab_ld", 32'(bus.cnt_ld), 0);
    step();
    bus.abort = 0;
    chk("r_ab_idle", 32'(bus.busy), 0);

    // Abort in RUN at count 4
    go(0, 9, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("a_cnt", 32'(bus.count), 4);
    chk("a_inc_pre", 32'(bus.cnt_inc), 1);
    bus.abort = 1;
    #1;
    chk("a_inc", 32'(bus.cnt_inc), 0);
    chk("a_done", 32'(bus.done), 0);
    chk("a_busy", 32'(bus.busy), 1);
    step();
    chk("a_idle", 32'(bus.busy), 0);
    chk("a_done2", 32'(bus.done), 0);
    bus.start = 1;
    step();
    chk("as_idle", 32'(bus.busy), 0);
    chk("as_ld", 32'(bus.cnt_ld), 0);
    bus.start = 0;
    bus.abort = 0;

    // Reset mid-run with start held
    go(2, 20, 1, 0);
    step(); step(); step();
    chk("x_busy", 32'(bus.busy), 1);
    rst = 0;
    bus.start = 1;
    bus.start_val = 5; bus.end_val = 6; bus.prescale = 0; bus.mode_reload = 0;
    step();
    chk("x_ld",   32'(bus.cnt_ld), 0);
    chk("x_inc",  32'(bus.cnt_inc), 0);
    chk("x_v",    32'(bus.cnt_v), 0);
    chk("x_busy2", 32'(bus.busy), 0);
    chk("x_done", 32'(bus.done), 0);
    rst = 1;
    step();
    bus.start = 0;
    chk("x_ld2", 32'(bus.cnt_ld), 1);
    chk("x_v2",  32'(bus.cnt_v), 5);
    run_seq(incs, dones, lds, cyc);
    chk("x_incs",  32'(incs), 1);
    chk("x_dones", 32'(dones), 1);
    chk("x_cnt",   32'(cnt_q), 6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer that drives an external up-counter through its load/increment interface (ld, v, inc). It runs a counter from a programmed start value to a programmed end value, paced by a programmable prescaler, and signals completion. It supports one-shot and auto-reload modes and is the sole driver of the counter's ld/v/inc inputs.

Parameters:
WIDTH, 8, width of counter value, start/end values and count feedback
PRE_W, 16, width of prescale value and internal prescale down-counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-low reset (0 = reset)
start  in  1  request a sequence; accepted only in IDLE
abort  in  1  terminate any active sequence
mode_reload  in  1  1 = auto-reload, 0 = one-shot; sampled on accepted start
start_val  in  WIDTH  value loaded into counter; sampled on accepted start
end_val  in  WIDTH  terminal count; sampled on accepted start
prescale  in  PRE_W  increment every prescale+1 cycles; sampled on accepted start
count  in  WIDTH  counter output feedback
cnt_ld  out  1  to counter ld
cnt_v  out  WIDTH  to counter v
cnt_inc  out  1  to counter inc
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on sequence completion

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Registered state, prescale down-counter pre_cnt, and latched config start_q, end_q, pre_q, reload_q.
- Reset: rst=0 at posedge -> state IDLE, pre_cnt=0, all latched config 0. Outputs in the following cycle: cnt_ld=0, cnt_inc=0, cnt_v=0, busy=0, done=0. rst has priority over start and abort.
- Outputs are decoded from registered state and count. cnt_ld = (state==LOAD) && !abort. cnt_v = start_q. cnt_inc = (state==RUN) && (pre_cnt==0) && (count!=end_q) && !abort. busy = (state!=IDLE). done = (state==DONE) && !abort.
- IDLE: start=1 and abort=0 at edge N -> latch config, go to LOAD. No other effect. Counter value is don't-care while in IDLE.
- LOAD (exactly one cycle): cnt_ld=1. At the next edge the counter holds start_q, state goes to RUN, and pre_cnt is set to pre_q.
- RUN, evaluated each cycle:
  - count==end_q -> next state DONE; no inc.
  - Otherwise, pre_cnt==0 -> cnt_inc=1 and pre_cnt reloads pre_q.
  - Otherwise -> pre_cnt decrements.
- RUN duration is D*(pre_q+1)+1 cycles, where D = (end_q-start_q) mod 2^WIDTH.
- Wrap-around: end_q below start_q is legal. The counter wraps through all-ones to 0.
- start_q==end_q: RUN lasts 1 cycle with no increment.
- DONE (exactly one cycle): done=1. Next state is LOAD if reload_q=1, otherwise IDLE. Reload reuses the latched config; input changes are ignored until the next accepted start.
- start outside IDLE is ignored. No queuing.
- abort=1 in LOAD, RUN or DONE at an edge -> next state IDLE. In the abort cycle, cnt_ld, cnt_inc and done are forced 0. abort in IDLE has no effect. abort together with start in IDLE -> remains IDLE.
- Config inputs are sampled only on an accepted start.

Test Plan:
- Basic one-shot: start at edge N with start=3, end=5, prescale=0, mode=0 -> cnt_ld=1, cnt_v=3 in cycle N+1 only; cnt_inc=1 in N+2 and N+3; count 3,4,5; done=1 in N+5 only; busy high N+1..N+5; IDLE at N+6.
- Prescale: start=0, end=2, prescale=3 -> cnt_inc high every 4th RUN cycle (RUN cycles 3 and 7); RUN lasts 9 cycles; done at LOAD cycle+10; start_val changed mid-run has no effect.
- Wrap and equal: WIDTH=8, start=254, end=1, prescale=0 -> count 254,255,0,1, 3 increments, done once. Then start=7, end=7 -> LOAD, 1 RUN cycle, done, no cnt_inc.
- Auto-reload: mode=1, start=0, end=1, prescale=0 -> repeating LOAD,RUN,RUN,DONE; done every 4 cycles; cnt_ld each period; start pulses while busy are ignored.
- Abort: abort=1 during RUN with count=4 (end=9) -> cnt_inc=0 that cycle, no done, IDLE next cycle, busy=0. abort+start together in IDLE -> stays IDLE.
- Reset mid-run: rst=0 during RUN with start=1 held -> next cycle all outputs 0, state IDLE. After rst=1, a new start runs normally from the new config.
